// File: rtl/writeback_stage_pkg.sv
// writeback_stage_pkg: shared types for the MEM/WB slice.
//   word_t / regbits_t : datapath word and register index
//   regsel_t           : writeback data source select
//   wbstate_t          : halt sequencer state (RUN / HALTED)
//   wblatch_t          : contents of the MEM/WB pipeline register
//   selectWdat         : writeback data mux
package writeback_stage_pkg;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  regbits_t;

   typedef enum logic [1:0] {
      SEL_ALU = 2'd0,
      SEL_MEM = 2'd1,
      SEL_NPC = 2'd2,
      SEL_LUI = 2'd3
   } regsel_t;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } wbstate_t;

   typedef struct packed {
      logic     v;
      logic     regWr;
      logic     haltBit;
      regsel_t  regSel;
      regbits_t regDst;
      word_t    nPC;
      word_t    ALUOut;
      word_t    dmemload;
   } wblatch_t;

   // The LUI immediate is already shifted in EX, so SEL_LUI carries ALUOut
   // just like SEL_ALU; it stays a separate code only for debug visibility.
   function automatic word_t selectWdat(input wblatch_t l);
      word_t d;
      case (l.regSel)
         SEL_MEM: d = l.dmemload;
         SEL_NPC: d = l.nPC;
         default: d = l.ALUOut;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// writeback_if: bundle between the memory stage / testbench and the
// writeback stage.
//   Inputs to WB : ihit, dhit, mem_valid, mem_memop, mem_halt and the *_next
//                  fields of the instruction currently in MEM.
//   Outputs of WB: register-file write port (wen/wsel/wdat), WB forwarding
//                  bus (fwd_en/fwd_reg/fwd_data), halt, retired count.
// Handshake: an instruction in MEM is taken exactly on the rising edge where
// mem_valid=1 and its completion qualifier is high (dhit for memory ops,
// ihit otherwise); MEM must hold its fields stable until that edge.
interface writeback_if
   import writeback_stage_pkg::*;
#(
   parameter int CNT_W = 32
) ();

   logic             ihit;
   logic             dhit;
   logic             mem_valid;
   logic             mem_memop;
   logic             mem_halt;
   word_t            nPC_next;
   logic             regWr_next;
   regsel_t          regSel_next;
   regbits_t         regDst_next;
   word_t            ALUOut_next;
   word_t            dmemload_next;

   logic             wen;
   regbits_t         wsel;
   word_t            wdat;
   logic             fwd_en;
   regbits_t         fwd_reg;
   word_t            fwd_data;
   logic             halt;
   logic [CNT_W-1:0] retired;

   modport wb (
      input  ihit, dhit, mem_valid, mem_memop, mem_halt,
      input  nPC_next, regWr_next, regSel_next, regDst_next,
      input  ALUOut_next, dmemload_next,
      output wen, wsel, wdat, fwd_en, fwd_reg, fwd_data, halt, retired
   );

   modport tb (
      output ihit, dhit, mem_valid, mem_memop, mem_halt,
      output nPC_next, regWr_next, regSel_next, regDst_next,
      output ALUOut_next, dmemload_next,
      input  wen, wsel, wdat, fwd_en, fwd_reg, fwd_data, halt, retired
   );

endinterface

// File: rtl/writeback_stage_latch.sv
// wb_latch: MEM/WB pipeline register.
//   CLK, RST        : clock, async active-high reset
//   freeze          : hold everything (CPU halted)
//   ihit, dhit      : advance qualifiers
//   mem_*, *_next   : instruction leaving MEM
//   latch           : registered instruction now in WB
// When the MEM instruction is not ready to advance a bubble is loaded, so a
// stalled instruction occupies WB for exactly one cycle once it completes.
module wb_latch
   import writeback_stage_pkg::*;
(
   input  logic     CLK,
   input  logic     RST,
   input  logic     freeze,
   input  logic     ihit,
   input  logic     dhit,
   input  logic     mem_valid,
   input  logic     mem_memop,
   input  logic     mem_halt,
   input  logic     regWr_next,
   input  regsel_t  regSel_next,
   input  regbits_t regDst_next,
   input  word_t    nPC_next,
   input  word_t    ALUOut_next,
   input  word_t    dmemload_next,
   output wblatch_t latch
);

   logic advance;

   // A memory op is done only when its data access completes; ihit alone
   // is not enough for it, and dhit alone means nothing for a non-memory op.
   assign advance = mem_valid & (mem_memop ? dhit : ihit);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         latch <= '0;
      end else if (!freeze) begin
         if (advance) begin
            latch.v        <= 1'b1;
            latch.regWr    <= regWr_next;
            latch.haltBit  <= mem_halt;
            latch.regSel   <= regSel_next;
            latch.regDst   <= regDst_next;
            latch.nPC      <= nPC_next;
            latch.ALUOut   <= ALUOut_next;
            latch.dmemload <= dmemload_next;
         end else begin
            // Bubble: data fields keep their old value, they are not used.
            latch.v       <= 1'b0;
            latch.regWr   <= 1'b0;
            latch.haltBit <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB register, writeback mux, halt sequencer and
// retired-instruction counter.
//   CLK, RST : clock, async active-high reset
//   bus      : writeback_if.wb (MEM inputs, regfile write port, forwarding,
//              halt, retired)
//   dbgState : current halt sequencer state
module writeback_stage
   import writeback_stage_pkg::*;
#(
   parameter int CNT_W      = 32,
   parameter bit ZERO_GUARD = 1'b1
) (
   input  logic     CLK,
   input  logic     RST,
   writeback_if.wb  bus,
   output wbstate_t dbgState
);

   wblatch_t         latch;
   wbstate_t         state;
   logic [CNT_W-1:0] retiredQ;
   logic             halted;
   logic             zeroDst;
   logic             wenC;
   word_t            wdatC;

   assign halted = (state == HALTED);

   wb_latch u_latch (
      .CLK           (CLK),
      .RST           (RST),
      .freeze        (halted),
      .ihit          (bus.ihit),
      .dhit          (bus.dhit),
      .mem_valid     (bus.mem_valid),
      .mem_memop     (bus.mem_memop),
      .mem_halt      (bus.mem_halt),
      .regWr_next    (bus.regWr_next),
      .regSel_next   (bus.regSel_next),
      .regDst_next   (bus.regDst_next),
      .nPC_next      (bus.nPC_next),
      .ALUOut_next   (bus.ALUOut_next),
      .dmemload_next (bus.dmemload_next),
      .latch         (latch)
   );

   assign zeroDst = ZERO_GUARD && (latch.regDst == '0);
   assign wdatC   = selectWdat(latch);
   // HALT itself never writes, even if its decode asserted regWr.
   assign wenC    = latch.v & latch.regWr & ~latch.haltBit & ~halted & ~zeroDst;

   // Halt sequencer and retire counter. Each instruction sits in WB for a
   // single cycle, so counting v once per edge counts each one once.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= RUN;
         retiredQ <= '0;
      end else begin
         case (state)
            RUN: begin
               if (latch.v) begin
                  if (retiredQ != '1) retiredQ <= retiredQ + CNT_W'(1);
                  if (latch.haltBit) state <= HALTED;
               end
            end
            HALTED: state <= HALTED;
            default: state <= RUN;
         endcase
      end
   end

   assign bus.wen      = wenC;
   assign bus.wsel     = latch.regDst;
   assign bus.wdat     = wdatC;
   assign bus.fwd_en   = wenC;
   assign bus.fwd_reg  = latch.regDst;
   assign bus.fwd_data = wdatC;
   assign bus.halt     = halted;
   assign bus.retired  = retiredQ;
   assign dbgState     = state;

endmodule
